// File: rtl/ayatsuki_dual_port_ram_if.sv
// ayatsuki_dual_port_ram_if
//   Bundles the instruction and data port signals of ayatsuki_dual_port_ram.
//   The master modport is the requester side (core or testbench).
//   The slave modport is the memory side.
//
// Port summary:
//   Instruction port: i_req_i, i_addr_i  -> i_data_o, i_valid_o, i_err_o
//   Data port:        d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i
//                                        -> d_rdata_o, d_valid_o, d_err_o
//
// The _i/_o suffixes are named from the memory's point of view.
interface ayatsuki_dual_port_ram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic                  i_req_i;
  logic [ADDR_WIDTH-1:0] i_addr_i;
  logic [DATA_WIDTH-1:0] i_data_o;
  logic                  i_valid_o;
  logic                  i_err_o;

  logic                  d_req_i;
  logic                  d_we_i;
  logic [BYTES-1:0]      d_be_i;
  logic [ADDR_WIDTH-1:0] d_addr_i;
  logic [DATA_WIDTH-1:0] d_wdata_i;
  logic [DATA_WIDTH-1:0] d_rdata_o;
  logic                  d_valid_o;
  logic                  d_err_o;

  modport master (
    output i_req_i, i_addr_i,
    input  i_data_o, i_valid_o, i_err_o,
    output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    input  d_rdata_o, d_valid_o, d_err_o
  );

  modport slave (
    input  i_req_i, i_addr_i,
    output i_data_o, i_valid_o, i_err_o,
    input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    output d_rdata_o, d_valid_o, d_err_o
  );
endinterface

// File: rtl/ayatsuki_dual_port_ram.sv
// ayatsuki_dual_port_ram
//   Byte-addressed, big-endian dual-port memory.
//   The instruction port is read-only. The data port reads and writes.
//   Both ports are fully pipelined, with a read latency of RD_LATENCY cycles.
//   Out-of-range requests are flagged with an error bit, read as zero,
//   and write nothing.
//
// Ports:
//   clk     sole clock, rising edge
//   rst     synchronous active-high reset (memory contents are kept)
//   io_ram  ayatsuki_dual_port_ram_if.slave carrying both request/response ports
//
// Optional feature:
//   AYATSUKI_RAM_BYPASS_EN  when defined, a data-port write in the same cycle
//                           forwards its strobed bytes to an overlapping
//                           instruction-port read. When undefined, the
//                           instruction port always sees the pre-write bytes.
module ayatsuki_dual_port_ram #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_BYTES = 2048,
  parameter int RD_LATENCY  = 1
) (
  input logic                    clk,
  input logic                    rst,
  ayatsuki_dual_port_ram_if.slave io_ram
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(DEPTH_BYTES);
  // Highest legal base address. It is compared one bit wider than the address,
  // so a base near the top of the address space cannot wrap into low memory.
  localparam logic [ADDR_WIDTH:0] LAST_OK = (ADDR_WIDTH+1)'(DEPTH_BYTES - BYTES);

  logic [7:0] r_mem [DEPTH_BYTES];

  logic [RD_LATENCY-1:0] r_iValid;
  logic [RD_LATENCY-1:0] r_iErr;
  logic [DATA_WIDTH-1:0] r_iData [RD_LATENCY];
  logic [RD_LATENCY-1:0] r_dValid;
  logic [RD_LATENCY-1:0] r_dErr;
  logic [DATA_WIDTH-1:0] r_dData [RD_LATENCY];

  logic             w_iInRange;
  logic             w_dInRange;
  logic [IDX_W-1:0] w_iIdx;
  logic [IDX_W-1:0] w_dIdx;
  logic             w_dWrite;
  logic [DATA_WIDTH-1:0] w_iRead;
  logic [DATA_WIDTH-1:0] w_dRead;

  assign w_iInRange = ({1'b0, io_ram.i_addr_i} <= LAST_OK);
  assign w_dInRange = ({1'b0, io_ram.d_addr_i} <= LAST_OK);
  // Only the low bits index storage. For an in-range base, base+k stays below
  // DEPTH_BYTES, so no carry out of IDX_W bits can occur.
  assign w_iIdx     = io_ram.i_addr_i[IDX_W-1:0];
  assign w_dIdx     = io_ram.d_addr_i[IDX_W-1:0];
  assign w_dWrite   = io_ram.d_req_i & io_ram.d_we_i & w_dInRange & ~rst;

  // Assemble the instruction-port word, with the lowest address in the MSB lane.
  // With bypass compiled in, a same-cycle write overrides the stored copy of
  // each byte it strobes.
  always_comb begin
    w_iRead = '0;
    for (int k = 0; k < BYTES; k++) begin
      w_iRead[DATA_WIDTH-1-8*k -: 8] = r_mem[w_iIdx + IDX_W'(k)];
    end
`ifdef AYATSUKI_RAM_BYPASS_EN
    if (w_dWrite && w_iInRange) begin
      for (int k = 0; k < BYTES; k++) begin
        for (int j = 0; j < BYTES; j++) begin
          if ((w_iIdx + IDX_W'(k)) == (w_dIdx + IDX_W'(j)) && io_ram.d_be_i[BYTES-1-j]) begin
            w_iRead[DATA_WIDTH-1-8*k -: 8] = io_ram.d_wdata_i[DATA_WIDTH-1-8*j -: 8];
          end
        end
      end
    end
`endif
  end

  // Assemble the data-port read word. The port never reads and writes in the
  // same cycle, so it has no bypass path.
  always_comb begin
    w_dRead = '0;
    for (int k = 0; k < BYTES; k++) begin
      w_dRead[DATA_WIDTH-1-8*k -: 8] = r_mem[w_dIdx + IDX_W'(k)];
    end
  end

  // Byte-strobed storage write. Strobe bit BYTES-1 covers the byte at the base
  // address. Storage has no reset, but w_dWrite is already blocked while rst is high.
  always_ff @(posedge clk) begin
    if (w_dWrite) begin
      for (int k = 0; k < BYTES; k++) begin
        if (io_ram.d_be_i[BYTES-1-k]) begin
          r_mem[w_dIdx + IDX_W'(k)] <= io_ram.d_wdata_i[DATA_WIDTH-1-8*k -: 8];
        end
      end
    end
  end

  // Instruction-port pipeline. The valid bit shifts every cycle. Error and data
  // move only behind a valid bit, so the output stage holds its last response
  // while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_iValid <= '0;
      r_iErr   <= '0;
      for (int s = 0; s < RD_LATENCY; s++) r_iData[s] <= '0;
    end else begin
      r_iValid[0] <= io_ram.i_req_i;
      if (io_ram.i_req_i) begin
        r_iErr[0]  <= ~w_iInRange;
        r_iData[0] <= w_iInRange ? w_iRead : '0;
      end
      for (int s = 1; s < RD_LATENCY; s++) begin
        r_iValid[s] <= r_iValid[s-1];
        if (r_iValid[s-1]) begin
          r_iErr[s]  <= r_iErr[s-1];
          r_iData[s] <= r_iData[s-1];
        end
      end
    end
  end

  // Data-port pipeline. Same structure as the instruction port.
  // Write responses carry zero data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dValid <= '0;
      r_dErr   <= '0;
      for (int s = 0; s < RD_LATENCY; s++) r_dData[s] <= '0;
    end else begin
      r_dValid[0] <= io_ram.d_req_i;
      if (io_ram.d_req_i) begin
        r_dErr[0]  <= ~w_dInRange;
        r_dData[0] <= (w_dInRange && !io_ram.d_we_i) ? w_dRead : '0;
      end
      for (int s = 1; s < RD_LATENCY; s++) begin
        r_dValid[s] <= r_dValid[s-1];
        if (r_dValid[s-1]) begin
          r_dErr[s]  <= r_dErr[s-1];
          r_dData[s] <= r_dData[s-1];
        end
      end
    end
  end

  assign io_ram.i_valid_o = r_iValid[RD_LATENCY-1];
  assign io_ram.i_err_o   = r_iErr[RD_LATENCY-1];
  assign io_ram.i_data_o  = r_iData[RD_LATENCY-1];
  assign io_ram.d_valid_o = r_dValid[RD_LATENCY-1];
  assign io_ram.d_err_o   = r_dErr[RD_LATENCY-1];
  assign io_ram.d_rdata_o = r_dData[RD_LATENCY-1];

endmodule

// File: tb/tb_ayatsuki_dual_port_ram.sv
// tb_ayatsuki_dual_port_ram
//   Drives three copies of the RAM (RD_LATENCY = 1, 2, 3) with identical
//   directed stimulus. Each copy is checked against hand-computed words at its
//   own latency.
module tb_ayatsuki_dual_port_ram;

  logic clk;
  logic rst;

  logic        iReq;
  logic [31:0] iAddr;
  logic        dReq;
  logic        dWe;
  logic [3:0]  dBe;
  logic [31:0] dAddr;
  logic [31:0] dWdata;

  logic [2:0]       iValidV, iErrV, dValidV, dErrV;
  logic [2:0][31:0] iDataV, dDataV;

  int nCheck;
  int nBad;

`ifdef AYATSUKI_RAM_BYPASS_EN
  localparam logic [31:0] COLL_FULL = 32'hDEADBEEF;
  localparam logic [31:0] COLL_PART = 32'hDEAD1122;
`else
  localparam logic [31:0] COLL_FULL = 32'h00000000;
  localparam logic [31:0] COLL_PART = 32'hDEADBEEF;
`endif

  // One interface and one RAM per latency, all sharing the same request inputs.
  for (genvar g = 0; g < 3; g++) begin : gDut
    ayatsuki_dual_port_ram_if ram ();

    ayatsuki_dual_port_ram #(.RD_LATENCY(g + 1)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_ram (ram)
    );

    assign ram.i_req_i   = iReq;
    assign ram.i_addr_i  = iAddr;
    assign ram.d_req_i   = dReq;
    assign ram.d_we_i    = dWe;
    assign ram.d_be_i    = dBe;
    assign ram.d_addr_i  = dAddr;
    assign ram.d_wdata_i = dWdata;

    assign iValidV[g] = ram.i_valid_o;
    assign iErrV[g]   = ram.i_err_o;
    assign iDataV[g]  = ram.i_data_o;
    assign dValidV[g] = ram.d_valid_o;
    assign dErrV[g]   = ram.d_err_o;
    assign dDataV[g]  = ram.d_rdata_o;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A sequence of up to five per-cycle steps, each with its expected responses.
  int          sqLen;
  logic        sqIReq   [5];
  logic [31:0] sqIAddr  [5];
  logic [31:0] sqIExp   [5];
  logic        sqIErr   [5];
  logic        sqDReq   [5];
  logic        sqDWe    [5];
  logic [3:0]  sqDBe    [5];
  logic [31:0] sqDAddr  [5];
  logic [31:0] sqDWdata [5];
  logic [31:0] sqDExp   [5];
  logic        sqDErr   [5];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCheck++;
    if (observed !== expected) begin
      nBad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic clearSeq(input int len);
    sqLen = len;
    for (int i = 0; i < 5; i++) begin
      sqIReq[i] = 0; sqIAddr[i] = '0; sqIExp[i] = '0; sqIErr[i] = 0;
      sqDReq[i] = 0; sqDWe[i] = 0; sqDBe[i] = '0; sqDAddr[i] = '0;
      sqDWdata[i] = '0; sqDExp[i] = '0; sqDErr[i] = 0;
    end
  endtask

  task automatic setI(input int idx, input logic [31:0] addr, input logic [31:0] exp, input logic err);
    sqIReq[idx] = 1; sqIAddr[idx] = addr; sqIExp[idx] = exp; sqIErr[idx] = err;
  endtask

  task automatic setD(input int idx, input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp, input logic err);
    sqDReq[idx] = 1; sqDWe[idx] = we; sqDBe[idx] = be; sqDAddr[idx] = addr;
    sqDWdata[idx] = wdata; sqDExp[idx] = exp; sqDErr[idx] = err;
  endtask

  task automatic driveIdle();
    iReq = 0; iAddr = '0; dReq = 0; dWe = 0; dBe = '0; dAddr = '0; dWdata = '0;
  endtask

  // Plays the sequence one step per edge. After each edge k, the RAM with
  // latency g+1 must present the response to step k-g, and nothing otherwise.
  task automatic applyStimulus(input string name);
    for (int k = 0; k < sqLen + 4; k++) begin
      if (k < sqLen) begin
        iReq = sqIReq[k]; iAddr = sqIAddr[k];
        dReq = sqDReq[k]; dWe = sqDWe[k]; dBe = sqDBe[k];
        dAddr = sqDAddr[k]; dWdata = sqDWdata[k];
      end else begin
        driveIdle();
      end
      @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        int  j;
        logic expI, expD;
        j = k - g;
        expI = 0;
        expD = 0;
        if (j >= 0 && j < sqLen) begin
          expI = sqIReq[j];
          expD = sqDReq[j];
        end
        checkOutput($sformatf("%s L%0d k%0d i_valid", name, g + 1, k), {31'b0, iValidV[g]}, {31'b0, expI});
        checkOutput($sformatf("%s L%0d k%0d d_valid", name, g + 1, k), {31'b0, dValidV[g]}, {31'b0, expD});
        if (expI) begin
          checkOutput($sformatf("%s L%0d k%0d i_data", name, g + 1, k), iDataV[g], sqIExp[j]);
          checkOutput($sformatf("%s L%0d k%0d i_err", name, g + 1, k), {31'b0, iErrV[g]}, {31'b0, sqIErr[j]});
        end
        if (expD) begin
          checkOutput($sformatf("%s L%0d k%0d d_rdata", name, g + 1, k), dDataV[g], sqDExp[j]);
          checkOutput($sformatf("%s L%0d k%0d d_err", name, g + 1, k), {31'b0, dErrV[g]}, {31'b0, sqDErr[j]});
        end
      end
    end
  endtask

  task automatic checkAllZero(input string name);
    for (int g = 0; g < 3; g++) begin
      checkOutput($sformatf("%s L%0d i_valid", name, g + 1), {31'b0, iValidV[g]}, 32'h0);
      checkOutput($sformatf("%s L%0d i_err", name, g + 1), {31'b0, iErrV[g]}, 32'h0);
      checkOutput($sformatf("%s L%0d i_data", name, g + 1), iDataV[g], 32'h0);
      checkOutput($sformatf("%s L%0d d_valid", name, g + 1), {31'b0, dValidV[g]}, 32'h0);
      checkOutput($sformatf("%s L%0d d_err", name, g + 1), {31'b0, dErrV[g]}, 32'h0);
      checkOutput($sformatf("%s L%0d d_rdata", name, g + 1), dDataV[g], 32'h0);
    end
  endtask

  initial begin
    nCheck = 0;
    nBad   = 0;
    rst    = 1;
    driveIdle();
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 0;

    // Preload known contents, and read one preloaded word back on the I-port.
    clearSeq(5);
    setD(0, 1, 4'hF, 32'd4,    32'h00000000, 32'h0, 0);
    setD(1, 1, 4'hF, 32'd16,   32'h00000000, 32'h0, 0);
    setD(2, 1, 4'hF, 32'd8,    32'hAABBCCDD, 32'h0, 0);
    setD(3, 1, 4'hF, 32'd2044, 32'h5A6B7C8D, 32'h0, 0);
    setI(3, 32'd8, 32'hAABBCCDD, 0);
    setD(4, 1, 4'hF, 32'd0,    32'h11223344, 32'h0, 0);
    applyStimulus("preload");

    // Byte order, unaligned access, strobes and out-of-range requests.
    clearSeq(5);
    setD(0, 0, 4'h0, 32'd0, 32'h0, 32'h11223344, 0);
    setI(0, 32'd1, 32'h22334400, 0);
    setD(1, 0, 4'h0, 32'd1, 32'h0, 32'h22334400, 0);
    setI(1, 32'd0, 32'h11223344, 0);
    setD(2, 1, 4'b0101, 32'd8, 32'h01020304, 32'h0, 0);
    setI(2, 32'd2045, 32'h0, 1);
    setD(3, 0, 4'h0, 32'd8, 32'h0, 32'hAA02CC04, 0);
    setI(3, 32'hFFFFFFFE, 32'h0, 1);
    setD(4, 1, 4'hF, 32'd2045, 32'hFFFFFFFF, 32'h0, 1);
    setI(4, 32'd4, 32'h00000000, 0);
    applyStimulus("order");

    // Out-of-range write left memory intact; same-cycle I/D collisions.
    clearSeq(5);
    setD(0, 0, 4'h0, 32'd2045, 32'h0, 32'h0, 1);
    setI(0, 32'd2044, 32'h5A6B7C8D, 0);
    setD(1, 0, 4'h0, 32'd2044, 32'h0, 32'h5A6B7C8D, 0);
    setD(2, 1, 4'hF, 32'd16, 32'hDEADBEEF, 32'h0, 0);
    setI(2, 32'd16, COLL_FULL, 0);
    setD(3, 0, 4'h0, 32'd16, 32'h0, 32'hDEADBEEF, 0);
    setI(3, 32'd16, 32'hDEADBEEF, 0);
    setD(4, 1, 4'b1100, 32'd18, 32'h11223344, 32'h0, 0);
    setI(4, 32'd16, COLL_PART, 0);
    applyStimulus("collide");

    // Back-to-back I-reads, with D traffic interleaved.
    clearSeq(5);
    setI(0, 32'd0,  32'h11223344, 0);
    setI(1, 32'd4,  32'h00000000, 0);
    setI(2, 32'd8,  32'hAA02CC04, 0);
    setI(3, 32'd12, 32'hCAFEF00D, 0);
    setI(4, 32'd16, 32'hDEAD1122, 0);
    setD(0, 1, 4'hF, 32'd12, 32'hCAFEF00D, 32'h0, 0);
    setD(1, 0, 4'h0, 32'd12, 32'h0, 32'hCAFEF00D, 0);
    setD(2, 0, 4'h0, 32'd1,  32'h0, 32'h22334400, 0);
    setD(3, 0, 4'h0, 32'd16, 32'h0, 32'hDEAD1122, 0);
    applyStimulus("pipe");

    // Reset while reads are in flight, and a write presented during reset.
    iReq = 1; iAddr = 32'd0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstmf L1 i_valid", {31'b0, iValidV[0]}, 32'h1);
    checkOutput("rstmf L1 i_data", iDataV[0], 32'h11223344);
    rst = 1; iReq = 0;
    dReq = 1; dWe = 1; dBe = 4'hF; dAddr = 32'd0; dWdata = 32'hFFFFFFFF;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkAllZero($sformatf("rstmf c%0d", c));
    end
    rst = 0;
    driveIdle();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("postrst c%0d i_valid", c), {29'b0, iValidV}, 32'h0);
      checkOutput($sformatf("postrst c%0d d_valid", c), {29'b0, dValidV}, 32'h0);
    end
    clearSeq(1);
    setD(0, 0, 4'h0, 32'd0, 32'h0, 32'h11223344, 0);
    setI(0, 32'd0, 32'h11223344, 0);
    applyStimulus("afterrst");

    $display("test done: total=%0d bad=%0d", nCheck, nBad);
    $finish;
  end

endmodule
